// File: rtl/amber48_uart_tx.sv
// amber48_uart_tx - byte-wide UART transmitter fed by a small write FIFO.
// Frame: one start bit, 8 data bits LSB first, optional even parity bit,
// one stop bit; every bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: AMBER48_UART_PARITY_EN (adds the PARITY state).
// Writes are fire-and-forget: a byte arriving while the FIFO is full and
// nothing is being popped is dropped and latched in overflow_o.
module amber48_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       fifo_full_o,
    output logic       overflow_o,
    output logic       frame_done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    localparam logic [TMR_W-1:0] BIT_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef AMBER48_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Transmit FSM
    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       bit_cnt_d;
    logic             timer_zero;
    logic             shift_en;
    logic [7:0]       shift_q;
    logic             frame_done_d;

    // Registered outputs
    logic             tx_q;
    logic             busy_q;
    logic             overflow_q;
    logic             frame_done_q;

`ifdef AMBER48_UART_PARITY_EN
    logic             parity_q;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign timer_zero = (timer_q == '0);

    // A full FIFO still accepts a byte when the FSM pops in the same cycle,
    // so occupancy is unchanged and nothing is lost.
    assign push = valid_i && (!fifo_full || pop);

    // FIFO storage: data only, no reset needed; writes ignored during reset
    always_ff @(posedge clk_i) begin
        if (push && rst_ni) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow: set when a byte is dropped, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (valid_i && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    // FSM state, bit timer and data-bit counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic: every state holds for one full bit period, then advances
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        pop          = 1'b0;
        shift_en     = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    timer_d = BIT_LOAD;
                end
            end

            ST_START: begin
                if (timer_zero) begin
                    state_d = ST_DATA;
                    timer_d = BIT_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_DATA: begin
                if (timer_zero) begin
                    shift_en  = 1'b1;
                    timer_d   = BIT_LOAD;
                    // 3-bit counter wraps 7 -> 0 as the last data bit ends
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef AMBER48_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

`ifdef AMBER48_UART_PARITY_EN
            ST_PARITY: begin
                if (timer_zero) begin
                    state_d = ST_STOP;
                    timer_d = BIT_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (timer_zero) begin
                    frame_done_d = 1'b1;
                    // Chain straight into the next frame when data is waiting
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                        timer_d = BIT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Shift register: loaded from the FIFO head on pop, shifted right per data bit
    always_ff @(posedge clk_i) begin
        if (pop) begin
            shift_q <= mem[rd_ptr_q];
        end else if (shift_en) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

`ifdef AMBER48_UART_PARITY_EN
    // Even parity of the byte, captured once when it leaves the FIFO
    always_ff @(posedge clk_i) begin
        if (pop) begin
            parity_q <= ^mem[rd_ptr_q];
        end
    end
`endif

    // Output registers: line level follows the current state one clock later
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            busy_q       <= !fifo_empty || (state_q != ST_IDLE);
            case (state_q)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shift_q[0];
`ifdef AMBER48_UART_PARITY_EN
                ST_PARITY: tx_q <= parity_q;
`endif
                default:   tx_q <= 1'b1;
            endcase
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_full_o  = fifo_full;
    assign overflow_o   = overflow_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: doc/amber48_uart_tx.md
AMBER48_UART_TX -- requirements
Module: amber48_uart_tx

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4: byte entries in the transmit FIFO; power of two, 2..16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: single-cycle byte strobe from the dmem UART TX register.
REQ-006 The block SHALL have port data_i, input, 8 bits: byte to send, qualified by valid_i.
REQ-007 The block SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high while FIFO non-empty or FSM not IDLE.
REQ-009 The block SHALL have port fifo_full_o, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-010 The block SHALL have port overflow_o, output, 1 bit: sticky flag, byte dropped.
REQ-011 The block SHALL have port frame_done_o, output, 1 bit: one-cycle pulse at end of each stop bit.

Function
REQ-012 valid_i with FIFO not full SHALL write data_i into the FIFO at that edge; no backpressure exists.
REQ-013 valid_i with FIFO full and no pop in the same cycle SHALL drop the byte, leave FIFO unchanged, and set overflow_o.
REQ-014 valid_i with FIFO full and a pop in the same cycle SHALL be accepted; the FIFO stays full.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (see REQ-027), STOP.
REQ-016 In IDLE with FIFO non-empty, the FSM SHALL pop the head byte into the shift register and enter START at the same edge.
REQ-017 tx_o SHALL be registered: low in START, shift-register bit 0 in DATA (LSB first), high in STOP and IDLE.
REQ-018 Each state SHALL last exactly CLKS_PER_BIT cycles, using a bit timer loaded with CLKS_PER_BIT-1 and counting down to 0.
REQ-019 DATA SHALL last 8 bit periods, using a 3-bit counter that wraps 7->0 on exit.
REQ-020 Latency: valid_i sampled at edge N into an empty FIFO while IDLE SHALL drive tx_o low from edge N+2.
REQ-021 At the end of STOP, the FSM SHALL pulse frame_done_o, then pop and enter START directly if the FIFO is non-empty (no idle gap), else enter IDLE.
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.
REQ-023 The FIFO SHALL use wrap-around read/write pointers plus an occupancy count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-024 While rst_ni is low at a clock edge, the block SHALL force: tx_o=1, busy_o=0, fifo_full_o=0, overflow_o=0, frame_done_o=0, FSM=IDLE, FIFO empty, timer=0, bit counter=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with tx_o high from the next edge; queued bytes SHALL be discarded.
REQ-026 valid_i during reset SHALL be ignored.

Configuration
REQ-027 With macro AMBER48_UART_PARITY_EN defined, the FSM SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-028 Without AMBER48_UART_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: one valid_i with 0x41 -> tx_o low from edge N+2 for 4 cycles; bits 1,0,0,0,0,0,1,0 at 4 cycles each; high stop; frame_done_o pulses once at cycle 40 of the frame; busy_o falls the next cycle.
REQ-030 Back-to-back: valid_i with 0x55 then 0xAA on consecutive cycles -> two frames with no idle cycle between stop and start; 80 cycles total; two frame_done_o pulses.
REQ-031 Overflow: 6 consecutive valid_i (0x01..0x06) while IDLE -> first byte popped; 0x02..0x05 queued; fifo_full_o high; 0x06 dropped; overflow_o=1 and held; serial output 0x01..0x05 only.
REQ-032 Reset mid-frame: rst_ni low for 1 cycle during DATA bit 3 of 0xF0 with 2 bytes queued -> tx_o=1 and busy_o=0 next edge; no further frames; overflow_o=0.
REQ-033 Parity (AMBER48_UART_PARITY_EN): send 0x07 -> parity bit 1, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-034 Full plus simultaneous pop: FIFO full at STOP end with valid_i 0x99 in the pop cycle -> byte accepted; overflow_o stays 0; 0x99 transmitted last.
